// File: rtl/dmem_lsu_if.sv
// Core <-> data-memory LSU bus: request fields from decode/ALU, result and
// handshake status back to the pipeline.
interface dmem_lsu_if #(
  parameter int N = 32
);
  logic         mem_read;
  logic         mem_write;
  logic [N-1:0] address;
  logic [N-1:0] wdata;
  logic [2:0]   fn3;
  logic [N-1:0] mem_out;
  logic         stall;
  logic         done;
  logic         fault;

  // Core side drives requests, sees results.
  modport master (
    output mem_read, mem_write, address, wdata, fn3,
    input  mem_out, stall, done, fault
  );

  // LSU side.
  modport slave (
    input  mem_read, mem_write, address, wdata, fn3,
    output mem_out, stall, done, fault
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: multicycle access to a word-organised array
// split into four byte lanes, with sub-word stores and sign/zero-extended
// loads. Misaligned, illegal or conflicting requests raise a fault pulse.

// One byte lane of the data array; not reset, contents undefined until written.
module dmem_lsu_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [7:0]    wbyte_i,
  output logic [7:0]    rbyte_o
);
  logic [7:0] mem_q [DEPTH];

  // Byte write on the commit edge.
  always_ff @(posedge clk)
    if (we_i) mem_q[idx_i] <= wbyte_i;

  assign rbyte_o = mem_q[idx_i];
endmodule

module dmem_lsu #(
  parameter int N           = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_lsu_if.slave   bus
);
  localparam int           AW      = $clog2(DEPTH);
  localparam logic [3:0]   WC      = 4'(WAIT_CYCLES);
  localparam bit           NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          rd_q, wr_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [2:0]    fn3_q;
  logic [N-1:0]  wdata_q;
  logic [N-1:0]  mem_out_q;
  logic          done_q, fault_q;

  logic          is_idle, req_rd, req_wr, req_any, both, legal, misal;
  logic          accept, bad, fin, commit;
  logic          c_rd, c_wr;
  logic [AW-1:0] c_idx;
  logic [1:0]    c_lane;
  logic [2:0]    c_fn3;
  logic [N-1:0]  c_wdata;
  logic [31:0]   wd;
  logic [3:0]    be;
  logic [3:0][7:0] wbytes, rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [N-1:0]  ld_val;
  logic          unused_addr;

  assign is_idle = (state_q == S_IDLE);
  assign req_rd  = bus.mem_read & ~bus.mem_write;
  assign req_wr  = bus.mem_write & ~bus.mem_read;
  assign req_any = req_rd | req_wr;
  assign both    = bus.mem_read & bus.mem_write;

  // Legal fn3 encodings differ between loads and stores.
  always_comb begin
    legal = 1'b0;
    if (req_rd)      legal = bus.fn3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (req_wr) legal = bus.fn3 inside {3'b000, 3'b001, 3'b010};
  end

  assign misal  = ((bus.fn3[1:0] == 2'b01) & bus.address[0]) |
                  ((bus.fn3[1:0] == 2'b10) & (bus.address[1:0] != 2'b00));
  assign accept = reset & is_idle & req_any & legal & ~misal;
  assign bad    = reset & is_idle & (both | (req_any & (~legal | misal)));

  // Access completes on this edge: zero-wait accept, or last wait cycle.
  assign fin    = reset & ((accept & NO_WAIT) | ((state_q == S_WAIT) & (cnt_q == 4'd1)));

  // In IDLE the live request is used (zero-wait path); afterwards the latched one.
  assign c_rd    = is_idle ? req_rd                     : rd_q;
  assign c_wr    = is_idle ? req_wr                     : wr_q;
  assign c_idx   = is_idle ? bus.address[AW+1:2]        : idx_q;
  assign c_lane  = is_idle ? bus.address[1:0]           : lane_q;
  assign c_fn3   = is_idle ? bus.fn3                    : fn3_q;
  assign c_wdata = is_idle ? bus.wdata                  : wdata_q;
  assign wd      = c_wdata[31:0];
  assign commit  = fin & c_wr;

  // Lane enables and replicated store data by access size.
  always_comb begin
    be     = 4'b0000;
    wbytes = wd;
    case (c_fn3[1:0])
      2'b00: begin
        wbytes = {4{wd[7:0]}};
        if (commit) be[c_lane] = 1'b1;
      end
      2'b01: begin
        wbytes = {2{wd[15:0]}};
        if (commit) be = c_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: if (commit) be = 4'b1111;
    endcase
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    dmem_lsu_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk     (clk),
      .we_i    (be[l]),
      .idx_i   (c_idx),
      .wbyte_i (wbytes[l]),
      .rbyte_o (rd_word[l])
    );
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    byte_v = rd_word[c_lane];
    half_v = c_lane[1] ? rd_word[3:2] : rd_word[1:0];
    case (c_fn3[1:0])
      2'b00:   ld_val = {{(N-8){byte_v[7] & ~c_fn3[2]}}, byte_v};
      2'b01:   ld_val = {{(N-16){half_v[15] & ~c_fn3[2]}}, half_v};
      default: ld_val = N'(rd_word);
    endcase
  end

  // Request FSM with registered result and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      lane_q    <= '0;
      fn3_q     <= '0;
      wdata_q   <= '0;
      mem_out_q <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      done_q  <= fin;
      fault_q <= bad;
      if (fin & c_rd) mem_out_q <= ld_val;
      case (state_q)
        S_IDLE: if (accept) begin
          rd_q    <= req_rd;
          wr_q    <= req_wr;
          idx_q   <= bus.address[AW+1:2];
          lane_q  <= bus.address[1:0];
          fn3_q   <= bus.fn3;
          wdata_q <= bus.wdata;
          if (NO_WAIT) state_q <= S_DONE;
          else begin
            state_q <= S_WAIT;
            cnt_q   <= WC;
          end
        end
        S_WAIT: if (cnt_q == 4'd1) begin
          state_q <= S_DONE;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q - 4'd1;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall   = accept | (reset & (state_q == S_WAIT));
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.mem_out = mem_out_q;

  // Upper address bits are ignored so accesses wrap around the array.
  assign unused_addr = ^bus.address[N-1:AW+2];
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one DUT with two wait states, one with none.
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.N(32)) a_if ();
  dmem_lsu_if #(.N(32)) b_if ();

  dmem_lsu #(.N(32), .DEPTH(256), .WAIT_CYCLES(2)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  dmem_lsu #(.N(32), .DEPTH(256), .WAIT_CYCLES(0)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  int checks = 0;
  int failures = 0;

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    if (sel == 0) begin
      a_if.mem_read = r; a_if.mem_write = w; a_if.address = a; a_if.wdata = d; a_if.fn3 = f;
    end else begin
      b_if.mem_read = r; b_if.mem_write = w; b_if.address = a; b_if.wdata = d; b_if.fn3 = f;
    end
  endtask

  task automatic peek(input int sel, output logic st, output logic dn, output logic ft,
                      output logic [31:0] mo);
    if (sel == 0) begin st = a_if.stall; dn = a_if.done; ft = a_if.fault; mo = a_if.mem_out; end
    else          begin st = b_if.stall; dn = b_if.done; ft = b_if.fault; mo = b_if.mem_out; end
  endtask

  // Issue one request for a single cycle, then scramble the inputs while
  // watching 8 cycles: stall count, cycle of first done (-1 if none), fault pulses.
  task automatic acc(input int sel, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f,
                     output int ns, output int dl, output int fl, output logic [31:0] mo);
    logic st, dn, ft;
    ns = 0; dl = -1; fl = 0;
    @(posedge clk); #1;
    drive(sel, r, w, a, d, f);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      peek(sel, st, dn, ft, mo);
      if (st) ns++;
      if (dn && dl < 0) dl = c;
      if (ft) fl++;
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, ~a, ~d, 3'b111);
    end
  endtask

  task automatic test_reset();
    logic st, dn, ft; logic [31:0] mo;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    repeat (2) @(negedge clk);
    peek(0, st, dn, ft, mo);
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", st); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", dn); end
    checks++; if (ft !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", ft); end
    checks++; if (mo !== 32'h0) begin failures++; $display("FAIL rst_memout got=%h exp=0", mo); end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    reset = 1'b1;
  endtask

  task automatic test_word();
    int ns, dl, fl; logic [31:0] mo;
    acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, ns, dl, fl, mo);
    checks++; if (ns !== 3) begin failures++; $display("FAIL sw_stall got=%0d exp=3", ns); end
    checks++; if (dl !== 3) begin failures++; $display("FAIL sw_done_lat got=%0d exp=3", dl); end
    acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, ns, dl, fl, mo);
    checks++; if (ns !== 3) begin failures++; $display("FAIL lw_stall got=%0d exp=3", ns); end
    checks++; if (dl !== 3) begin failures++; $display("FAIL lw_done_lat got=%0d exp=3", dl); end
    checks++; if (mo !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", mo); end
  endtask

  task automatic test_byte();
    int ns, dl, fl; logic [31:0] mo;
    acc(0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, ns, dl, fl, mo);
    acc(0, 1'b0, 1'b1, 32'h13, 32'hABCDEF80, 3'b000, ns, dl, fl, mo);
    acc(0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b000, ns, dl, fl, mo);
    checks++; if (mo !== 32'hFFFFFF80) begin failures++; $display("FAIL lb got=%h exp=ffffff80", mo); end
    acc(0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b100, ns, dl, fl, mo);
    checks++; if (mo !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", mo); end
    acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, ns, dl, fl, mo);
    checks++; if (mo !== 32'h80000000) begin failures++; $display("FAIL sb_lanes got=%h exp=80000000", mo); end
  endtask

  task automatic test_half();
    int ns, dl, fl; logic [31:0] mo;
    acc(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, ns, dl, fl, mo);
    acc(0, 1'b0, 1'b1, 32'h22, 32'h55558001, 3'b001, ns, dl, fl, mo);
    acc(0, 1'b1, 1'b0, 32'h22, 32'h0, 3'b001, ns, dl, fl, mo);
    checks++; if (mo !== 32'hFFFF8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", mo); end
    acc(0, 1'b1, 1'b0, 32'h22, 32'h0, 3'b101, ns, dl, fl, mo);
    checks++; if (mo !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h exp=00008001", mo); end
    acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, ns, dl, fl, mo);
    checks++; if (mo !== 32'h80013344) begin failures++; $display("FAIL sh_lanes got=%h exp=80013344", mo); end
  endtask

  task automatic test_faults();
    int ns, dl, fl; logic [31:0] mo;
    logic r_t [5]; logic w_t [5]; logic [31:0] a_t [5]; logic [2:0] f_t [5];
    r_t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    w_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    a_t = '{32'h11, 32'h21, 32'h20, 32'h20, 32'h20};
    f_t = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, ns, dl, fl, mo);
    for (int i = 0; i < 5; i++) begin
      acc(0, r_t[i], w_t[i], a_t[i], 32'hFFFFFFFF, f_t[i], ns, dl, fl, mo);
      checks++; if (fl !== 1) begin failures++; $display("FAIL fault%0d_pulses got=%0d exp=1", i, fl); end
      checks++; if (ns !== 0) begin failures++; $display("FAIL fault%0d_stall got=%0d exp=0", i, ns); end
      checks++; if (dl !== -1) begin failures++; $display("FAIL fault%0d_done got=%0d exp=-1", i, dl); end
      checks++; if (mo !== 32'h80000000) begin failures++; $display("FAIL fault%0d_memout got=%h exp=80000000", i, mo); end
    end
    acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, ns, dl, fl, mo);
    checks++; if (mo !== 32'h80013344) begin failures++; $display("FAIL fault_nowrite got=%h exp=80013344", mo); end
  endtask

  task automatic test_reset_abort();
    int ns, dl, fl; logic [31:0] mo; logic st, dn, ft;
    acc(0, 1'b0, 1'b1, 32'h04, 32'h0, 3'b010, ns, dl, fl, mo);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h04, 32'h12345678, 3'b010);
    @(negedge clk);
    peek(0, st, dn, ft, mo);
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL abort_accept_stall got=%b exp=1", st); end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    reset = 1'b0;
    @(negedge clk);
    peek(0, st, dn, ft, mo);
    checks++; if (mo !== 32'h0) begin failures++; $display("FAIL abort_memout got=%h exp=0", mo); end
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b exp=0", st); end
    @(posedge clk); #1;
    reset = 1'b1;
    fl = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      peek(0, st, dn, ft, mo);
      if (dn) fl++;
    end
    checks++; if (fl !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", fl); end
    acc(0, 1'b1, 1'b0, 32'h04, 32'h0, 3'b010, ns, dl, fl, mo);
    checks++; if (dl !== 3) begin failures++; $display("FAIL post_rst_lat got=%0d exp=3", dl); end
    checks++; if (mo !== 32'h0) begin failures++; $display("FAIL abort_nocommit got=%h exp=0", mo); end
  endtask

  task automatic test_wrap();
    int ns, dl, fl; logic [31:0] mo;
    acc(0, 1'b0, 1'b1, 32'h408, 32'hA5A5A5A5, 3'b010, ns, dl, fl, mo);
    acc(0, 1'b1, 1'b0, 32'h08, 32'h0, 3'b010, ns, dl, fl, mo);
    checks++; if (mo !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap_a got=%h exp=a5a5a5a5", mo); end
    acc(1, 1'b0, 1'b1, 32'h408, 32'h5A5A5A5A, 3'b010, ns, dl, fl, mo);
    checks++; if (ns !== 1) begin failures++; $display("FAIL w0_sw_stall got=%0d exp=1", ns); end
    checks++; if (dl !== 1) begin failures++; $display("FAIL w0_sw_lat got=%0d exp=1", dl); end
    acc(1, 1'b1, 1'b0, 32'h08, 32'h0, 3'b010, ns, dl, fl, mo);
    checks++; if (dl !== 1) begin failures++; $display("FAIL w0_lw_lat got=%0d exp=1", dl); end
    checks++; if (mo !== 32'h5A5A5A5A) begin failures++; $display("FAIL wrap_b got=%h exp=5a5a5a5a", mo); end
  endtask

  // Held load on the zero-wait DUT: DONE never re-accepts, so accepts alternate.
  task automatic test_back_to_back();
    int nd, ns; logic st, dn, ft; logic [31:0] mo;
    nd = 0; ns = 0;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h08, 32'h0, 3'b000);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      peek(1, st, dn, ft, mo);
      if (dn) nd++;
      if (st) ns++;
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (nd !== 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", nd); end
    checks++; if (ns !== 3) begin failures++; $display("FAIL b2b_stalls got=%0d exp=3", ns); end
    checks++; if (mo !== 32'h0000005A) begin failures++; $display("FAIL b2b_lb got=%h exp=0000005a", mo); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
